// File: rtl/ifft_2_seq_if.sv
// Stream bundle for ifft_2_seq: an input valid/ready stream carrying complex
// frequency-domain samples and an output valid/ready stream carrying complex
// time-domain samples.
//   in_valid/in_ready/in_r/in_i            : input sample stream
//   out_valid/out_ready/out_r/out_i/out_last : output sample stream, out_last marks x1
// slave  : the transform block (consumes input stream, produces output stream)
// master : the surrounding logic (produces input stream, consumes output stream)
interface ifft_2_seq_if #(
  parameter int unsigned DATA_WIDTH = 64
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_r;
  logic [DATA_WIDTH-1:0] in_i;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_r;
  logic [DATA_WIDTH-1:0] out_i;
  logic                  out_last;

  modport slave (
    input  in_valid, in_r, in_i, out_ready,
    output in_ready, out_valid, out_r, out_i, out_last
  );

  modport master (
    output in_valid, in_r, in_i, out_ready,
    input  in_ready, out_valid, out_r, out_i, out_last
  );
endinterface

// File: rtl/ifft_2_seq.sv
// Sequential 2-point inverse FFT with 1/N scaling folded in.
// Accepts Y0 then Y1 on the input stream, produces x0 = (Y0 + Y1) / 2 and
// x1 = (Y0 - Y1) / 2 (floor division, per component) on the output stream.
//   clk : rising-edge clock
//   rst : synchronous active-high reset, discards any partial or unsent frame
//   bus : ifft_2_seq_if slave modport (input stream + output stream)
module ifft_2_seq #(
  parameter int unsigned DATA_WIDTH = 64
) (
  input logic         clk,
  input logic         rst,
  ifft_2_seq_if.slave bus
);
  localparam int unsigned W = DATA_WIDTH;

  typedef enum logic [1:0] {StIn0, StIn1, StOut0, StOut1} state_e;

  state_e state_q, state_d;

  logic [W-1:0] y0_r_q, y0_r_d, y0_i_q, y0_i_d;
  logic [W-1:0] x0_r_q, x0_r_d, x0_i_q, x0_i_d;
  logic [W-1:0] x1_r_q, x1_r_d, x1_i_q, x1_i_d;

  // One extra bit so the sum/difference never wraps before halving.
  logic signed [W:0] sum_r, sum_i, dif_r, dif_i;

  logic         in_ready, out_valid, out_last;
  logic [W-1:0] out_r, out_i;

  always_comb begin
    sum_r = {y0_r_q[W-1], y0_r_q} + {bus.in_r[W-1], bus.in_r};
    sum_i = {y0_i_q[W-1], y0_i_q} + {bus.in_i[W-1], bus.in_i};
    dif_r = {y0_r_q[W-1], y0_r_q} - {bus.in_r[W-1], bus.in_r};
    dif_i = {y0_i_q[W-1], y0_i_q} - {bus.in_i[W-1], bus.in_i};
  end

  always_comb begin
    state_d   = state_q;
    y0_r_d    = y0_r_q;
    y0_i_d    = y0_i_q;
    x0_r_d    = x0_r_q;
    x0_i_d    = x0_i_q;
    x1_r_d    = x1_r_q;
    x1_i_d    = x1_i_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_r     = x0_r_q;
    out_i     = x0_i_q;
    unique case (state_q)
      StIn0: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          y0_r_d  = bus.in_r;
          y0_i_d  = bus.in_i;
          state_d = StIn1;
        end
      end
      StIn1: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          // Arithmetic shift of the widened value is floor division by 2.
          x0_r_d  = W'(sum_r >>> 1);
          x0_i_d  = W'(sum_i >>> 1);
          x1_r_d  = W'(dif_r >>> 1);
          x1_i_d  = W'(dif_i >>> 1);
          state_d = StOut0;
        end
      end
      StOut0: begin
        out_valid = 1'b1;
        if (bus.out_ready) state_d = StOut1;
      end
      StOut1: begin
        out_valid = 1'b1;
        out_last  = 1'b1;
        out_r     = x1_r_q;
        out_i     = x1_i_q;
        if (bus.out_ready) state_d = StIn0;
      end
      default: state_d = StIn0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIn0;
      y0_r_q  <= '0;
      y0_i_q  <= '0;
      x0_r_q  <= '0;
      x0_i_q  <= '0;
      x1_r_q  <= '0;
      x1_i_q  <= '0;
    end else begin
      state_q <= state_d;
      y0_r_q  <= y0_r_d;
      y0_i_q  <= y0_i_d;
      x0_r_q  <= x0_r_d;
      x0_i_q  <= x0_i_d;
      x1_r_q  <= x1_r_d;
      x1_i_q  <= x1_i_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_last  = out_last;
  assign bus.out_r     = out_r;
  assign bus.out_i     = out_i;
endmodule

// File: tb/tb_ifft_2_seq.sv
// Directed self-checking bench for ifft_2_seq (DATA_WIDTH = 64).
module tb_ifft_2_seq;
  localparam int unsigned W = 64;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  ifft_2_seq_if #(.DATA_WIDTH(W)) bus ();

  ifft_2_seq #(.DATA_WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [63:0] Max = 64'h7fff_ffff_ffff_ffff;
  localparam logic [63:0] Min = 64'h8000_0000_0000_0000;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input string tag, input logic [63:0] r, input logic [63:0] i);
    int n;
    bus.in_valid = 1'b1;
    bus.in_r     = r;
    bus.in_i     = i;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 20) begin
      n++;
      @(negedge clk);
    end
    check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
    step();
    bus.in_valid = 1'b0;
    bus.in_r     = {$urandom, $urandom};
    bus.in_i     = {$urandom, $urandom};
  endtask

  task automatic recv(input string tag, input logic [63:0] r, input logic [63:0] i,
                      input logic last);
    int n;
    bus.out_ready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.out_valid && n < 20) begin
      n++;
      @(negedge clk);
    end
    check({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
    check({tag, "_r"}, bus.out_r, r);
    check({tag, "_i"}, bus.out_i, i);
    check({tag, "_last"}, 64'(bus.out_last), 64'(last));
    step();
  endtask

  task automatic frame(input string tag,
                       input logic [63:0] y0r, input logic [63:0] y0i,
                       input logic [63:0] y1r, input logic [63:0] y1i,
                       input logic [63:0] x0r, input logic [63:0] x0i,
                       input logic [63:0] x1r, input logic [63:0] x1i);
    send({tag, "_y0"}, y0r, y0i);
    send({tag, "_y1"}, y1r, y1i);
    recv({tag, "_x0"}, x0r, x0i, 1'b0);
    recv({tag, "_x1"}, x1r, x1i, 1'b1);
  endtask

  // Back-to-back stimulus: three frames and their expected outputs.
  logic [63:0] bb_in_r  [6];
  logic [63:0] bb_in_i  [6];
  logic [63:0] bb_out_r [6];
  logic [63:0] bb_out_i [6];

  initial begin
    int idx;
    int oidx;
    checks        = 0;
    errors        = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_r      = '0;
    bus.in_i      = '0;
    bus.out_ready = 1'b0;

    bb_in_r  = '{64'(1), 64'(3), -64'(4), -64'(6), 64'(0), 64'(5)};
    bb_in_i  = '{64'(1), 64'(5), 64'(7), -64'(1), -64'(9), 64'(2)};
    bb_out_r = '{64'(2), -64'(1), -64'(5), 64'(1), 64'(2), -64'(3)};
    bb_out_i = '{64'(3), -64'(2), 64'(3), 64'(4), -64'(4), -64'(6)};

    // Reset values.
    step();
    step();
    @(negedge clk);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_last", 64'(bus.out_last), 64'd0);
    check("rst_out_r", bus.out_r, 64'd0);
    check("rst_out_i", bus.out_i, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Basic frame, cycle by cycle, in_valid held high.
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_r = 64'(4);
    bus.in_i = 64'(2);
    @(negedge clk);
    check("basic_c0_in_ready", 64'(bus.in_ready), 64'd1);
    check("basic_c0_out_valid", 64'(bus.out_valid), 64'd0);
    step();
    bus.in_r = 64'(2);
    bus.in_i = -64'(2);
    @(negedge clk);
    check("basic_c1_in_ready", 64'(bus.in_ready), 64'd1);
    check("basic_c1_out_valid", 64'(bus.out_valid), 64'd0);
    step();
    bus.in_r = 64'(99);
    bus.in_i = 64'(99);
    @(negedge clk);
    check("basic_c2_in_ready", 64'(bus.in_ready), 64'd0);
    check("basic_c2_out_valid", 64'(bus.out_valid), 64'd1);
    check("basic_x0_r", bus.out_r, 64'(3));
    check("basic_x0_i", bus.out_i, 64'(0));
    check("basic_x0_last", 64'(bus.out_last), 64'd0);
    step();
    @(negedge clk);
    check("basic_c3_in_ready", 64'(bus.in_ready), 64'd0);
    check("basic_c3_out_valid", 64'(bus.out_valid), 64'd1);
    check("basic_x1_r", bus.out_r, 64'(1));
    check("basic_x1_i", bus.out_i, 64'(2));
    check("basic_x1_last", 64'(bus.out_last), 64'd1);
    step();
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("basic_c4_out_valid", 64'(bus.out_valid), 64'd0);
    check("basic_c4_in_ready", 64'(bus.in_ready), 64'd1);
    step();

    // Rounding, sign and extremes.
    frame("round_a", 64'(3), -64'(3), 64'(0), 64'(0),
          64'(1), -64'(2), 64'(1), -64'(2));
    frame("round_b", 64'(1), 64'(0), 64'(2), 64'(0),
          64'(1), 64'(0), -64'(1), 64'(0));
    frame("ext_a", Max, Min, Max, Min, Max, Min, 64'(0), 64'(0));
    frame("ext_b", Max, 64'(0), Min, 64'(0), -64'(1), 64'(0), Max, 64'(0));

    // Backpressure in S_OUT0 with in_valid asserted (must be ignored).
    bus.out_ready = 1'b0;
    send("bp_y0", 64'(10), 64'(6));
    send("bp_y1", 64'(4), 64'(2));
    bus.in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_out_valid", 64'(bus.out_valid), 64'd1);
      check("bp_out_r", bus.out_r, 64'(7));
      check("bp_out_i", bus.out_i, 64'(4));
      check("bp_out_last", 64'(bus.out_last), 64'd0);
      check("bp_in_ready", 64'(bus.in_ready), 64'd0);
      step();
    end
    bus.in_valid = 1'b0;
    recv("bp_x0", 64'(7), 64'(4), 1'b0);
    recv("bp_x1", 64'(3), 64'(2), 1'b1);

    // in_valid gaps 1,0,0,1 with junk on the data lines while idle.
    send("gap_y0", 64'(6), 64'(0));
    step();
    step();
    send("gap_y1", 64'(2), 64'(4));
    recv("gap_x0", 64'(4), 64'(2), 1'b0);
    recv("gap_x1", 64'(2), -64'(2), 1'b1);

    // Reset after Y0 is accepted: stale Y0 must not be used.
    send("rst_mid_y0", 64'(100), 64'(100));
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_mid_out_valid", 64'(bus.out_valid), 64'd0);
    step();
    frame("rst_mid", 64'(8), 64'(8), 64'(2), 64'(2), 64'(5), 64'(5), 64'(3), 64'(3));

    // Reset while x1 is presented.
    bus.out_ready = 1'b0;
    send("rst_out_y0", 64'(20), 64'(2));
    send("rst_out_y1", 64'(10), 64'(2));
    recv("rst_out_x0", 64'(15), 64'(2), 1'b0);
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("rst_out_pre_last", 64'(bus.out_last), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_last", 64'(bus.out_last), 64'd0);
    step();

    // Three back-to-back frames in 12 cycles.
    bus.out_ready = 1'b1;
    idx  = 0;
    oidx = 0;
    for (int c = 0; c < 12; c++) begin
      bus.in_valid = (idx < 6);
      bus.in_r     = (idx < 6) ? bb_in_r[idx] : 64'(0);
      bus.in_i     = (idx < 6) ? bb_in_i[idx] : 64'(0);
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) idx++;
      if (bus.out_valid) begin
        if (oidx < 6) begin
          check("b2b_r", bus.out_r, bb_out_r[oidx]);
          check("b2b_i", bus.out_i, bb_out_i[oidx]);
          check("b2b_last", 64'(bus.out_last), 64'(oidx % 2));
        end
        oidx++;
      end
      step();
    end
    bus.in_valid = 1'b0;
    check("b2b_inputs", 64'(idx), 64'd6);
    check("b2b_outputs", 64'(oidx), 64'd6);
    @(negedge clk);
    check("b2b_idle", 64'(bus.out_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
